// File: rtl/sized_regfile_if.sv
`default_nettype none
// ============================================================================
//  sized_regfile_if : write/invalidate/dual-read bus of the sized register bank
//  Rev 1.0
// ============================================================================
interface sized_regfile_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [1:0]       wsize;
    logic             wsext;
    logic [WIDTH-1:0] wdata;
    logic             inv;
    logic [AW-1:0]    iaddr;
    logic [AW-1:0]    raddr0;
    logic [AW-1:0]    raddr1;
    logic [1:0]       rsize0;
    logic [1:0]       rsize1;
    logic             rsext0;
    logic             rsext1;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
    logic             rsign0;
    logic             rsign1;
    logic             rvalid0;
    logic             rvalid1;
    logic [DEPTH-1:0] vmask;

    modport master (
        output we, waddr, wsize, wsext, wdata, inv, iaddr,
               raddr0, raddr1, rsize0, rsize1, rsext0, rsext1,
        input  rdata0, rdata1, rsign0, rsign1, rvalid0, rvalid1, vmask
    );

    modport slave (
        input  we, waddr, wsize, wsext, wdata, inv, iaddr,
               raddr0, raddr1, rsize0, rsize1, rsext0, rsext1,
        output rdata0, rdata1, rsign0, rsign1, rvalid0, rvalid1, vmask
    );
endinterface
`default_nettype wire

// File: rtl/sized_regfile.sv
`default_nettype none
// ============================================================================
//  sized_regfile : DEPTH x WIDTH register bank, x86-style partial writes,
//                  two size/extension-selecting read ports, valid tracking
//  Rev 1.0
// ============================================================================
module sized_regfile #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int BYPASS = 1
) (
    input  logic           CLK,
    input  logic           CLR,
    sized_regfile_if.slave bus
);
    localparam int c_NB = WIDTH / 8;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    logic [WIDTH-1:0] w_old;
    logic [WIDTH-1:0] w_wmerge;
    logic [c_NB-1:0]  w_lane_en;
    logic [c_NB-1:0]  w_in_size;
    logic [1:0]       w_wsz;
    logic             w_wsign;
    logic             w_byp;
    logic             w_hit0;
    logic             w_hit1;
    logic [WIDTH-1:0] w_e0;
    logic [WIDTH-1:0] w_e1;
    logic [WIDTH:0]   w_r0;
    logic [WIDTH:0]   w_r1;

    // A 32-bit bank has no qword: size 11 collapses onto dword.
    function automatic logic [1:0] f_size(input logic [1:0] sz);
        return (WIDTH == 32 && sz == 2'b11) ? 2'b10 : sz;
    endfunction

    function automatic logic [WIDTH:0] f_read(input logic [WIDTH-1:0] e,
                                              input logic [1:0]       sz,
                                              input logic             sext);
        logic [1:0]       s2;
        logic             sgn;
        logic [WIDTH-1:0] keep;
        s2 = f_size(sz);
        case (s2)
            2'b00:   begin sgn = e[7];       keep = WIDTH'(8'hFF);         end
            2'b01:   begin sgn = e[15];      keep = WIDTH'(16'hFFFF);      end
            2'b10:   begin sgn = e[31];      keep = WIDTH'(32'hFFFF_FFFF); end
            default: begin sgn = e[WIDTH-1]; keep = '1;                    end
        endcase
        return {sgn, (e & keep) | (~keep & {WIDTH{sgn & sext}})};
    endfunction

    // ---------------- write path: per-lane merge ----------------
    assign w_old = regs_q[bus.waddr];
    assign w_wsz = f_size(bus.wsize);

    always_comb begin
        case (w_wsz)
            2'b00:   w_wsign = bus.wdata[7];
            2'b01:   w_wsign = bus.wdata[15];
            2'b10:   w_wsign = bus.wdata[31];
            default: w_wsign = bus.wdata[WIDTH-1];
        endcase
    end

    for (genvar b = 0; b < c_NB; b++) begin : g_lane
        if (b == 0) begin : g_l0
            assign w_lane_en[b] = 1'b1;
            assign w_in_size[b] = 1'b1;
        end else if (b == 1) begin : g_l1
            assign w_lane_en[b] = (bus.wsize != 2'b00) || bus.wsext;
            assign w_in_size[b] = (w_wsz != 2'b00);
        end else if (b < 4) begin : g_l23
            assign w_lane_en[b] = bus.wsize[1] || bus.wsext;
            assign w_in_size[b] = w_wsz[1];
        end else begin : g_l47
            assign w_lane_en[b] = (bus.wsize == 2'b11) || bus.wsext;
            assign w_in_size[b] = (w_wsz == 2'b11);
        end
        // Lanes above the write size only open for sign extension.
        assign w_wmerge[8*b +: 8] = !w_lane_en[b] ? w_old[8*b +: 8] :
                                    w_in_size[b]  ? bus.wdata[8*b +: 8] :
                                                    {8{w_wsign}};
    end

    // A write to the same address as an invalidate wins.
    always_comb begin
        valid_d = valid_q;
        if (bus.inv) valid_d[bus.iaddr] = 1'b0;
        if (bus.we)  valid_d[bus.waddr] = 1'b1;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            if (bus.we) regs_q[bus.waddr] <= w_wmerge;
        end
    end

    // ---------------- read ports ----------------
    assign w_byp  = (BYPASS != 0) && bus.we && !CLR;
    assign w_hit0 = w_byp && (bus.waddr == bus.raddr0);
    assign w_hit1 = w_byp && (bus.waddr == bus.raddr1);
    assign w_e0   = w_hit0 ? w_wmerge : regs_q[bus.raddr0];
    assign w_e1   = w_hit1 ? w_wmerge : regs_q[bus.raddr1];
    assign w_r0   = f_read(w_e0, bus.rsize0, bus.rsext0);
    assign w_r1   = f_read(w_e1, bus.rsize1, bus.rsext1);

    assign bus.rdata0  = w_r0[WIDTH-1:0];
    assign bus.rsign0  = w_r0[WIDTH];
    assign bus.rvalid0 = w_hit0 | valid_q[bus.raddr0];
    assign bus.rdata1  = w_r1[WIDTH-1:0];
    assign bus.rsign1  = w_r1[WIDTH];
    assign bus.rvalid1 = w_hit1 | valid_q[bus.raddr1];
    assign bus.vmask   = valid_q;
endmodule
`default_nettype wire

// File: tb/tb_sized_regfile.sv
`default_nettype none
// ============================================================================
//  tb_sized_regfile : table + scoreboard bench for sized_regfile (32-bit with
//                     and without bypass, 64-bit)
//  Rev 1.0
// ============================================================================
module tb_sized_regfile;
    logic clk = 1'b0;
    logic clr1, clr0, clr64;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sized_regfile_if #(.WIDTH(32), .DEPTH(8), .AW(3)) b1 ();
    sized_regfile_if #(.WIDTH(32), .DEPTH(8), .AW(3)) b0 ();
    sized_regfile_if #(.WIDTH(64), .DEPTH(8), .AW(3)) b64 ();

    sized_regfile #(.WIDTH(32), .DEPTH(8), .AW(3), .BYPASS(1)) u_byp (.CLK(clk), .CLR(clr1),  .bus(b1));
    sized_regfile #(.WIDTH(32), .DEPTH(8), .AW(3), .BYPASS(0)) u_nob (.CLK(clk), .CLR(clr0),  .bus(b0));
    sized_regfile #(.WIDTH(64), .DEPTH(8), .AW(3), .BYPASS(1)) u_w64 (.CLK(clk), .CLR(clr64), .bus(b64));

    typedef struct {
        logic we; logic [2:0] wa; logic [1:0] ws; logic wx; logic [31:0] wd;
        logic inv; logic [2:0] ia;
        logic [2:0] ra0; logic [1:0] rs0; logic rx0;
        logic [2:0] ra1; logic [1:0] rs1; logic rx1;
        logic [31:0] d0; logic s0; logic v0;
        logic [31:0] d1; logic s1; logic v1;
        logic [7:0] vm;
    } vec_t;

    typedef struct {
        int idx;
        logic [31:0] d0; logic s0; logic v0;
        logic [31:0] d1; logic s1; logic v1;
        logic [7:0] vm;
    } exp_t;

    vec_t vt [16];
    exp_t sb [$];

    function automatic vec_t mkv(
        input logic we, input logic [2:0] wa, input logic [1:0] ws, input logic wx, input logic [31:0] wd,
        input logic inv, input logic [2:0] ia,
        input logic [2:0] ra0, input logic [1:0] rs0, input logic rx0,
        input logic [2:0] ra1, input logic [1:0] rs1, input logic rx1,
        input logic [31:0] d0, input logic s0, input logic v0,
        input logic [31:0] d1, input logic s1, input logic v1,
        input logic [7:0] vm);
        vec_t v;
        v.we = we; v.wa = wa; v.ws = ws; v.wx = wx; v.wd = wd; v.inv = inv; v.ia = ia;
        v.ra0 = ra0; v.rs0 = rs0; v.rx0 = rx0; v.ra1 = ra1; v.rs1 = rs1; v.rx1 = rx1;
        v.d0 = d0; v.s0 = s0; v.v0 = v0; v.d1 = d1; v.s1 = s1; v.v1 = v1; v.vm = vm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_all();
        b1.we = 0;  b1.waddr = 0;  b1.wsize = 0;  b1.wsext = 0;  b1.wdata = 0;  b1.inv = 0;  b1.iaddr = 0;
        b1.raddr0 = 0;  b1.raddr1 = 0;  b1.rsize0 = 2;  b1.rsize1 = 2;  b1.rsext0 = 0;  b1.rsext1 = 0;
        b0.we = 0;  b0.waddr = 0;  b0.wsize = 0;  b0.wsext = 0;  b0.wdata = 0;  b0.inv = 0;  b0.iaddr = 0;
        b0.raddr0 = 0;  b0.raddr1 = 0;  b0.rsize0 = 2;  b0.rsize1 = 2;  b0.rsext0 = 0;  b0.rsext1 = 0;
        b64.we = 0; b64.waddr = 0; b64.wsize = 0; b64.wsext = 0; b64.wdata = 0; b64.inv = 0; b64.iaddr = 0;
        b64.raddr0 = 0; b64.raddr1 = 0; b64.rsize0 = 3; b64.rsize1 = 3; b64.rsext0 = 0; b64.rsext1 = 0;
    endtask

    initial begin
        exp_t e;
        // Expected outputs are sampled before the committing edge of each row.
        vt[0]  = mkv(0,0,0,0,32'h0,        0,0, 0,2,0, 0,2,0, 32'h0,0,0,        32'h0,0,0,        8'h00);
        vt[1]  = mkv(1,2,2,0,32'hAABBCCDD, 0,0, 2,2,0, 2,0,1, 32'hAABBCCDD,1,1, 32'hFFFFFFDD,1,1, 8'h00);
        vt[2]  = mkv(1,2,0,0,32'hFFFFFF11, 0,0, 2,2,0, 2,1,1, 32'hAABBCC11,1,1, 32'hFFFFCC11,1,1, 8'h04);
        vt[3]  = mkv(1,2,1,1,32'h12348001, 0,0, 2,2,0, 2,0,0, 32'hFFFF8001,1,1, 32'h00000001,0,1, 8'h04);
        vt[4]  = mkv(1,5,2,0,32'h000000F0, 0,0, 5,0,1, 5,0,0, 32'hFFFFFFF0,1,1, 32'h000000F0,1,1, 8'h04);
        vt[5]  = mkv(0,0,0,0,32'h0,        0,0, 5,1,1, 5,3,0, 32'h000000F0,0,1, 32'h000000F0,0,1, 8'h24);
        vt[6]  = mkv(1,1,2,0,32'h1,        0,0, 1,2,0, 2,2,1, 32'h00000001,0,1, 32'hFFFF8001,1,1, 8'h24);
        vt[7]  = mkv(1,1,0,0,32'h22,       0,0, 1,2,0, 1,0,1, 32'h00000022,0,1, 32'h00000022,0,1, 8'h26);
        vt[8]  = mkv(1,4,2,0,32'h44,       0,0, 4,2,0, 3,2,0, 32'h00000044,0,1, 32'h0,0,0,        8'h26);
        vt[9]  = mkv(1,6,2,0,32'h66,       1,4, 4,2,0, 6,2,0, 32'h00000044,0,1, 32'h00000066,0,1, 8'h36);
        vt[10] = mkv(0,0,0,0,32'h0,        0,0, 4,2,0, 6,2,0, 32'h00000044,0,0, 32'h00000066,0,1, 8'h66);
        vt[11] = mkv(1,6,2,0,32'h77,       1,6, 6,2,0, 4,2,0, 32'h00000077,0,1, 32'h00000044,0,0, 8'h66);
        vt[12] = mkv(0,0,0,0,32'h0,        0,0, 6,2,0, 7,0,1, 32'h00000077,0,1, 32'h0,0,0,        8'h66);
        vt[13] = mkv(1,6,0,1,32'h80,       0,0, 6,1,0, 6,2,1, 32'h0000FF80,1,1, 32'hFFFFFF80,1,1, 8'h66);
        vt[14] = mkv(1,7,3,0,32'h13572468, 0,0, 7,2,0, 7,1,1, 32'h13572468,0,1, 32'h00002468,0,1, 8'h66);
        vt[15] = mkv(0,0,0,0,32'h0,        0,0, 7,0,1, 6,0,1, 32'h00000068,0,1, 32'hFFFFFF80,1,1, 8'hE6);

        clr1 = 1; clr0 = 1; clr64 = 1;
        idle_all();
        @(negedge clk);
        chk("reset rdata0", b1.rdata0, 0);
        chk("reset rvalid0", b1.rvalid0, 0);
        chk("reset vmask", b1.vmask, 0);
        chk("reset vmask64", b64.vmask, 0);
        @(posedge clk); #1;
        clr1 = 0; clr0 = 0; clr64 = 0;

        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            b1.we = vt[k].we; b1.waddr = vt[k].wa; b1.wsize = vt[k].ws; b1.wsext = vt[k].wx;
            b1.wdata = vt[k].wd; b1.inv = vt[k].inv; b1.iaddr = vt[k].ia;
            b1.raddr0 = vt[k].ra0; b1.rsize0 = vt[k].rs0; b1.rsext0 = vt[k].rx0;
            b1.raddr1 = vt[k].ra1; b1.rsize1 = vt[k].rs1; b1.rsext1 = vt[k].rx1;
            e.idx = k; e.d0 = vt[k].d0; e.s0 = vt[k].s0; e.v0 = vt[k].v0;
            e.d1 = vt[k].d1; e.s1 = vt[k].s1; e.v1 = vt[k].v1; e.vm = vt[k].vm;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d rdata0", e.idx),  b1.rdata0,  e.d0);
            chk($sformatf("v%0d rsign0", e.idx),  b1.rsign0,  e.s0);
            chk($sformatf("v%0d rvalid0", e.idx), b1.rvalid0, e.v0);
            chk($sformatf("v%0d rdata1", e.idx),  b1.rdata1,  e.d1);
            chk($sformatf("v%0d rsign1", e.idx),  b1.rsign1,  e.s1);
            chk($sformatf("v%0d rvalid1", e.idx), b1.rvalid1, e.v1);
            chk($sformatf("v%0d vmask", e.idx),   b1.vmask,   e.vm);
        end
        @(posedge clk); #1;
        idle_all();

        // No bypass: write data appears one cycle late.
        b0.we = 1; b0.waddr = 1; b0.wsize = 2; b0.wdata = 32'h1; b0.raddr0 = 1;
        @(negedge clk);
        chk("nob first rdata0", b0.rdata0, 0);
        chk("nob first rvalid0", b0.rvalid0, 0);
        @(posedge clk); #1;
        b0.wsize = 0; b0.wdata = 32'h22;
        @(negedge clk);
        chk("nob old rdata0", b0.rdata0, 32'h1);
        chk("nob old rvalid0", b0.rvalid0, 1);
        @(posedge clk); #1;
        b0.we = 0;
        @(negedge clk);
        chk("nob new rdata0", b0.rdata0, 32'h22);
        chk("nob vmask", b0.vmask, 8'h02);

        // 64-bit bank.
        @(posedge clk); #1;
        b64.we = 1; b64.waddr = 0; b64.wsize = 3; b64.wdata = 64'h8000_0000_0000_0000;
        @(posedge clk); #1;
        b64.we = 0;
        b64.raddr0 = 0; b64.rsize0 = 3; b64.rsext0 = 1;
        b64.raddr1 = 0; b64.rsize1 = 2; b64.rsext1 = 1;
        @(negedge clk);
        chk("w64 qword rdata0", b64.rdata0, 64'h8000_0000_0000_0000);
        chk("w64 qword rsign0", b64.rsign0, 1);
        chk("w64 dword rdata1", b64.rdata1, 0);
        chk("w64 dword rsign1", b64.rsign1, 0);
        @(posedge clk); #1;
        b64.we = 1; b64.wsize = 0; b64.wsext = 0; b64.wdata = 64'hFFFF_FFFF_FFFF_FF7F;
        @(negedge clk);
        chk("w64 byte merge rdata0", b64.rdata0, 64'h8000_0000_0000_007F);
        chk("w64 byte merge rdata1", b64.rdata1, 64'h7F);
        @(posedge clk); #1;
        b64.waddr = 1; b64.wsize = 2; b64.wsext = 1; b64.wdata = 64'h0000_0000_8000_0000;
        b64.raddr1 = 1; b64.rsize1 = 3; b64.rsext1 = 0;
        @(negedge clk);
        chk("w64 dword sext rdata1", b64.rdata1, 64'hFFFF_FFFF_8000_0000);
        chk("w64 dword sext rsign1", b64.rsign1, 1);
        chk("w64 dword sext rvalid1", b64.rvalid1, 1);
        @(posedge clk); #1;
        b64.we = 0; b64.raddr0 = 1; b64.rsize0 = 2; b64.rsext0 = 0;
        @(negedge clk);
        chk("w64 dword zext rdata0", b64.rdata0, 64'h8000_0000);
        chk("w64 dword zext rsign0", b64.rsign0, 1);
        chk("w64 vmask", b64.vmask, 8'h03);

        // Reset asserted between edges while a write is held.
        @(posedge clk); #1;
        b1.we = 1; b1.waddr = 3; b1.wsize = 2; b1.wsext = 0; b1.wdata = 32'h12345678; b1.inv = 0;
        b1.raddr0 = 3; b1.rsize0 = 2; b1.rsext0 = 0;
        @(posedge clk); #1;
        b1.we = 0;
        @(negedge clk);
        chk("mid pre rdata0", b1.rdata0, 32'h12345678);
        chk("mid pre rvalid0", b1.rvalid0, 1);
        #1;
        clr1 = 1;
        b1.we = 1; b1.wdata = 32'hDEADBEEF;
        #1;
        chk("mid clr rdata0", b1.rdata0, 0);
        chk("mid clr rvalid0", b1.rvalid0, 0);
        chk("mid clr vmask", b1.vmask, 0);
        @(posedge clk); #1;
        chk("mid clr held rdata0", b1.rdata0, 0);
        @(negedge clk);
        clr1 = 0;
        b1.we = 0;
        #1;
        chk("mid post rdata0", b1.rdata0, 0);
        chk("mid post rvalid0", b1.rvalid0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sized_regfile.md
Name: sized_regfile

Overview:
- Parametrised register bank for the integer datapath: DEPTH registers of WIDTH bits.
- One write port and two read ports.
- Writes use x86 partial-register semantics: a byte, word or dword write merges into the stored value, preserving the upper bits. Optionally, the write value is sign-extended to full width instead.
- Each read port returns a size-selected, sign- or zero-extended value.
- Optional same-cycle write-to-read bypass.
- Per-register valid bits track which entries have been written since reset or invalidation.

Parameters:
- WIDTH, 32, register width; legal values 32 or 64.
- DEPTH, 8, number of registers; power of two, 2..32.
- AW, 3, address width; must equal log2(DEPTH).
- BYPASS, 1, 1 = read ports see a same-cycle write; 0 = new data is visible the cycle after the write.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  asynchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wsize  in  2  write size: 00 byte, 01 word, 10 dword, 11 qword.
- wsext  in  1  1 = sign-extend the write to full WIDTH; 0 = merge, preserving bits above the size.
- inv  in  1  invalidate enable.
- iaddr  in  AW  invalidate address.
- raddr0, raddr1  in  AW  read addresses.
- rsize0, rsize1  in  2  read size, same encoding as wsize.
- rsext0, rsext1  in  1  1 = sign-extend the read, 0 = zero-extend.
- rdata0, rdata1  out  WIDTH  extended read data.
- rsign0, rsign1  out  1  sign bit of the selected size (bit 7/15/31/63).
- rvalid0, rvalid1  out  1  valid bit of the addressed register.
- vmask  out  DEPTH  all valid bits; bit i = register i.

Behaviour:
- Reset: on CLR high, immediately (not clock-gated) all registers become 0 and all valid bits become 0. While CLR is high, rdata* = 0, rsign* = 0, rvalid* = 0, vmask = 0, and writes and invalidates are ignored. Deassertion is sampled on the next CLK edge.
- Size at WIDTH=32: size 11 is treated as 10 (dword = full width). Bit 63 does not exist; rsign uses bit 31.
- Write (we=1, rising edge):
  - wsext=0: reg[waddr] low S bits <- wdata low S bits; upper bits unchanged. S = 8/16/32/64 per wsize.
  - wsext=1: reg[waddr] <- wdata low S bits sign-extended to WIDTH.
  - Full-width size: both modes write all bits.
  - valid[waddr] <- 1.
- Invalidate (inv=1, rising edge): valid[iaddr] <- 0. Register data is unchanged.
- Simultaneous we and inv:
  - Same address: the write wins; valid = 1 and data is written.
  - Different addresses: both take effect.
- Read: combinational from the addressed register (effective value E).
  - rsign = bit S-1 of E.
  - rdata = E[S-1:0] extended with rsign (rsext=1) or zeros (rsext=0).
  - rvalid = valid[raddr].
- BYPASS=1 and we=1 and waddr==raddrN: E = the post-merge value being written this cycle, and rvalidN = 1. This applies even when inv targets the same address.
- BYPASS=0: E = stored value. The new value and valid bit appear after the edge.
- Both read ports are independent; reading the same address on both ports is legal.
- Latency:
  - Write to read: 0 cycles with BYPASS, 1 cycle without.
  - Read: combinational.
  - Invalidate: visible after the edge; there is no bypass for invalidate.
- Addresses: full AW range is always in range; no out-of-range case exists.
- Registers are built from enabled register cells with a merge mux per byte lane. Lane enables:
  - lane 0: always on a write.
  - lane 1: wsize >= 01 or wsext.
  - lanes 2-3: wsize >= 10 or wsext.
  - lanes 4-7: wsize == 11 or wsext.

Test Plan:
- Reset mid-operation: write 0x12345678 to r3, assert CLR between edges -> rdata0 (raddr0=3) = 0 and vmask = 0 immediately; a write held during CLR is not stored.
- Partial merge, WIDTH=32: write r2 = 0xAABBCCDD dword, then byte write 0x11 with wsext=0 -> read dword gives 0xAABBCC11. Then word 0x8001 with wsext=1 -> 0xFFFF8001.
- Read extension: r5 = 0x000000F0; byte read with rsext=1 -> 0xFFFFFFF0, rsign=1; with rsext=0 -> 0x000000F0; word read with rsext=1 -> 0x000000F0, rsign=0.
- Bypass: BYPASS=1, r1 = 0x1, same cycle write 0x22 byte to r1 with raddr0=1 -> rdata0 = 0x22 and rvalid0 = 1 in that cycle. BYPASS=0 -> rdata0 = 0x1, then 0x22 next cycle.
- Valid tracking: write r4, then inv r4 and we r6 together -> vmask bit 4 = 0, bit 6 = 1, and r4 data is retained. Then inv and we both to r6 -> valid[6] stays 1 with the new data.
- WIDTH=64: r0 = 0x8000000000000000 qword; rsize=11, rsext=1 -> same value, rsign=1. Dword read with rsext=1 -> 0, rsign=0.
